// File: rtl/rtc_tick_pkg.sv
// Shared types and helpers for the RTC tick generator.
// Holds the FSM state encoding and the increment clamp.
package rtc_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int unsigned ACC_WIDTH_DFLT = 32;
    localparam logic [63:0] INC_MAX = 64'd1 << (ACC_WIDTH_DFLT - 1);

    // Limit an increment to half the accumulator range so every rtc level
    // spans at least two aclk cycles.
    function automatic logic [63:0] clamp_inc(
        input logic [63:0] inc,
        input int unsigned aw
    );
        logic [63:0] lim;
        lim = 64'd1 << (aw - 1);
        return (inc > lim) ? lim : inc;
    endfunction

endpackage

// File: rtl/rtc_tick_gen_acc.sv
// Fractional phase accumulator for the RTC tick generator.
// Adds the increment when stepping and reports the carry out.
module rtc_phase_acc
    import rtc_tick_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 i_clear,
    input  logic                 i_step,
    input  logic [ACC_WIDTH-1:0] i_inc,
    output logic                 o_carry
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_inc};
    assign o_carry = w_sum[ACC_WIDTH];

    // Accumulator register: clear wins over step, otherwise hold.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/rtc_tick_gen.sv
// RTC square-wave generator feeding the CLINT rtc input.
// Phase-accumulator driven, with tick pulse, edge counter and halt freeze.
module rtc_tick_gen
    import rtc_tick_pkg::*;
#(
    parameter int                   ACC_WIDTH   = 32,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}},
    parameter int                   CNT_WIDTH   = 64
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable_i,
    input  logic                 debug_halt_i,
    input  logic [ACC_WIDTH-1:0] cfg_inc_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic                 rtc_o,
    output logic                 tick_o,
    output logic [CNT_WIDTH-1:0] rise_cnt_o
);

    state_e               r_state;
    state_e               w_next;
    logic [ACC_WIDTH-1:0] r_inc;
    logic [ACC_WIDTH-1:0] r_pend_inc;
    logic                 r_pend_valid;
    logic                 r_rtc;
    logic                 r_tick;
    logic [CNT_WIDTH-1:0] r_rise_cnt;

    logic                 w_step;
    logic                 w_clear;
    logic                 w_carry;
    logic                 w_carry_run;
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_apply;
    logic [ACC_WIDTH-1:0] w_clamp;

    // Next state plus the accumulator controls derived from it; disable
    // and halt take effect on the very edge that samples them.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (enable_i) w_next = RUN;
            RUN: begin
                if (!enable_i)        w_next = IDLE;
                else if (debug_halt_i) w_next = HALT;
            end
            HALT: begin
                if (!enable_i)         w_next = IDLE;
                else if (!debug_halt_i) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
        w_step  = (w_next == RUN) && (r_state != IDLE);
        w_clear = (w_next == IDLE);
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    rtc_phase_acc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .aclk    (aclk),
        .areset  (areset),
        .i_clear (w_clear),
        .i_step  (w_step),
        .i_inc   (r_inc),
        .o_carry (w_carry)
    );

    assign w_carry_run = w_step & w_carry;
    assign w_rise      = w_carry_run & ~r_rtc;
    assign w_clamp     = ACC_WIDTH'(clamp_inc(64'(cfg_inc_i), ACC_WIDTH));
    assign w_accept    = cfg_valid_i & ~r_pend_valid;
    assign w_apply     = r_pend_valid & (~w_step | (r_inc == '0) | w_carry);

    // Increment handshake: latch clamped value, swap it in on a carry
    // (or at once when not stepping or when no carry can ever come).
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_inc        <= DEFAULT_INC;
            r_pend_inc   <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_apply) begin
            r_inc        <= r_pend_inc;
            r_pend_valid <= 1'b0;
        end else if (w_accept) begin
            r_pend_inc   <= w_clamp;
            r_pend_valid <= 1'b1;
        end
    end

    // rtc level, rise pulse and rise counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rtc      <= 1'b0;
            r_tick     <= 1'b0;
            r_rise_cnt <= '0;
        end else begin
            r_tick <= w_rise;
            if (w_clear)          r_rtc <= 1'b0;
            else if (w_carry_run) r_rtc <= ~r_rtc;
            if (w_rise) r_rise_cnt <= r_rise_cnt + 1'b1;
        end
    end

    assign cfg_ready_o = ~r_pend_valid;
    assign rtc_o       = r_rtc;
    assign tick_o      = r_tick;
    assign rise_cnt_o  = r_rise_cnt;

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Directed bench for rtc_tick_gen with an 8-bit accumulator.
// Expected values are hand-derived edge by edge.
module tb_rtc_tick_gen;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable_i;
    logic        debug_halt_i;
    logic [7:0]  cfg_inc_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic        rtc_o;
    logic        tick_o;
    logic [15:0] rise_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic seen;

    rtc_tick_gen #(
        .ACC_WIDTH (8),
        .CNT_WIDTH (16)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .enable_i     (enable_i),
        .debug_halt_i (debug_halt_i),
        .cfg_inc_i    (cfg_inc_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .rtc_o        (rtc_o),
        .tick_o       (tick_o),
        .rise_cnt_o   (rise_cnt_o)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    function automatic logic [7:0] acc();
        return dut.u_acc.r_acc;
    endfunction

    initial begin
        areset = 1'b1;
        enable_i = 1'b0;
        debug_halt_i = 1'b0;
        cfg_inc_i = 8'd0;
        cfg_valid_i = 1'b0;
        step(2);
        chk("rst_rtc", rtc_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_cnt", rise_cnt_o, 0);
        chk("rst_ready", cfg_ready_o, 1);
        chk("rst_acc", acc(), 0);

        // default inc 128
        areset = 1'b0;
        enable_i = 1'b1;
        step(1);
        chk("e1_rtc", rtc_o, 0);
        chk("e1_acc", acc(), 0);
        step(1);
        chk("e2_acc", acc(), 128);
        chk("e2_rtc", rtc_o, 0);
        step(1);
        chk("e3_rtc", rtc_o, 1);
        chk("e3_tick", tick_o, 1);
        chk("e3_cnt", rise_cnt_o, 1);
        step(1);
        chk("e4_rtc", rtc_o, 1);
        chk("e4_tick", tick_o, 0);
        step(1);
        chk("e5_rtc", rtc_o, 0);
        step(96);
        chk("run100_cnt", rise_cnt_o, 25);
        chk("run100_rtc", rtc_o, 0);
        chk("run100_acc", acc(), 0);

        // switch to inc 64 mid-run
        cfg_valid_i = 1'b1;
        cfg_inc_i = 8'd64;
        step(1);
        cfg_valid_i = 1'b0;
        chk("c64_ready0", cfg_ready_o, 0);
        chk("c64_acc_old", acc(), 128);
        step(1);
        chk("c64_ready1", cfg_ready_o, 1);
        chk("c64_rise_old", rtc_o, 1);
        chk("c64_cnt", rise_cnt_o, 26);
        step(3);
        chk("c64_hold", rtc_o, 1);
        chk("c64_acc", acc(), 192);
        step(1);
        chk("c64_fall", rtc_o, 0);
        step(4);
        chk("c64_rise", rtc_o, 1);
        chk("c64_tick", tick_o, 1);
        chk("c64_cnt2", rise_cnt_o, 27);

        // 200 clamps to 128
        cfg_valid_i = 1'b1;
        cfg_inc_i = 8'd200;
        step(1);
        cfg_valid_i = 1'b0;
        chk("c200_ready0", cfg_ready_o, 0);
        step(3);
        chk("c200_ready1", cfg_ready_o, 1);
        chk("c200_fall", rtc_o, 0);
        step(2);
        chk("c200_rise", rtc_o, 1);
        chk("c200_cnt", rise_cnt_o, 28);
        step(1);
        chk("c200_min2", rtc_o, 1);
        step(1);
        chk("c200_fall2", rtc_o, 0);

        // inc 0 freezes rtc
        cfg_valid_i = 1'b1;
        cfg_inc_i = 8'd0;
        step(1);
        cfg_valid_i = 1'b0;
        step(1);
        chk("c0_rise_old", rtc_o, 1);
        chk("c0_cnt", rise_cnt_o, 29);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen = seen | tick_o | ~rtc_o;
        end
        chk("c0_frozen", seen, 0);
        chk("c0_cnt_hold", rise_cnt_o, 29);

        // back to 128, applied right after acceptance
        cfg_valid_i = 1'b1;
        cfg_inc_i = 8'd128;
        step(1);
        cfg_valid_i = 1'b0;
        chk("c128_ready0", cfg_ready_o, 0);
        step(1);
        chk("c128_ready1", cfg_ready_o, 1);
        step(2);
        chk("c128_fall", rtc_o, 0);
        step(2);
        chk("c128_rise", tick_o, 1);
        chk("c128_cnt", rise_cnt_o, 30);

        // debug halt for 10 cycles
        step(1);
        chk("h_pre_acc", acc(), 128);
        debug_halt_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | tick_o | ~rtc_o;
        end
        debug_halt_i = 1'b0;
        chk("h_acc", acc(), 128);
        chk("h_still", seen, 0);
        chk("h_cnt", rise_cnt_o, 30);
        step(1);
        chk("h_res_fall", rtc_o, 0);
        chk("h_res_acc", acc(), 0);
        step(2);
        chk("h_res_rise", tick_o, 1);
        chk("h_res_cnt", rise_cnt_o, 31);

        // disable while rtc high
        step(1);
        enable_i = 1'b0;
        step(1);
        chk("d_rtc", rtc_o, 0);
        chk("d_acc", acc(), 0);
        chk("d_cnt", rise_cnt_o, 31);
        step(1);
        enable_i = 1'b1;
        step(1);
        chk("d_en_rtc", rtc_o, 0);
        step(1);
        chk("d_en_acc", acc(), 128);
        step(1);
        chk("d_en_rise", rtc_o, 1);
        chk("d_en_cnt", rise_cnt_o, 32);

        // reset with a pending cfg
        cfg_valid_i = 1'b1;
        cfg_inc_i = 8'd64;
        step(1);
        cfg_valid_i = 1'b0;
        chk("r_pend", cfg_ready_o, 0);
        chk("r_rtc_hi", rtc_o, 1);
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        chk("r_rtc", rtc_o, 0);
        chk("r_tick", tick_o, 0);
        chk("r_cnt", rise_cnt_o, 0);
        chk("r_ready", cfg_ready_o, 1);
        chk("r_acc", acc(), 0);
        step(2);
        chk("r_inc128", acc(), 128);
        step(1);
        chk("r_rise", tick_o, 1);
        chk("r_cnt1", rise_cnt_o, 1);

        // counter wrap
        step(3);
        chk("w_pre", rtc_o, 0);
        force dut.r_rise_cnt = 16'hFFFF;
        #1;
        release dut.r_rise_cnt;
        step(1);
        chk("w_cnt", rise_cnt_o, 0);
        chk("w_tick", tick_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
